// File: rtl/qdr_backdoor_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qdr_backdoor_bridge_pkg
// Description : Shared types and lane helpers for the QDR host backdoor bridge.
//               Maps 32-bit host words to and from 36-bit QDR halves, where
//               each byte sits in a 9-bit lane with its parity bit on top.
// Revision    : 1.0 - initial release
// ============================================================================
package qdr_backdoor_bridge_pkg;

    localparam int HALF_W = 36;
    localparam int WORD_W = 72;

    // Bridge sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RWAIT = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // Spread four host bytes into 9-bit lanes; parity bits are written as zero
    function automatic logic [HALF_W-1:0] lane_pack(input logic [31:0] data);
        lane_pack = {1'b0, data[31:24], 1'b0, data[23:16],
                     1'b0, data[15:8],  1'b0, data[7:0]};
    endfunction

    // Collapse a 36-bit half back to 32 bits, dropping the parity bits
    function automatic logic [31:0] lane_unpack(input logic [HALF_W-1:0] half);
        lane_unpack = {half[34:27], half[25:18], half[16:9], half[7:0]};
    endfunction

    // Byte enables to 18-bit lane enables; only the selected half is enabled
    function automatic logic [3:0] lane_be(input logic [3:0] be, input logic hi);
        logic [1:0] lanes;
        lanes   = {be[3] | be[2], be[1] | be[0]};
        lane_be = hi ? {lanes, 2'b00} : {2'b00, lanes};
    endfunction

endpackage
`default_nettype wire

// File: rtl/qdr_backdoor_bridge.sv
`default_nettype none
// ============================================================================
// Module      : qdr_backdoor_bridge
// Description : Turns one 32-bit host register access into one QDR burst slot
//               on a 72-bit word. Writes ack right after the grant; reads wait
//               a fixed QDR latency, capture the selected half, then ack.
// Revision    : 1.0 - initial release
// ============================================================================
module qdr_backdoor_bridge
    import qdr_backdoor_bridge_pkg::*;
#(
    parameter int QDR_LATENCY = 10
) (
    input  logic        qdr_clk,
    input  logic        qdr_rst_n,
    input  logic        host_en,
    input  logic        host_rnw,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_datai,
    input  logic [3:0]  host_be,
    output logic [31:0] host_datao,
    output logic        host_ack,
    output logic        qdr_req,
    input  logic        qdr_ack,
    output logic [31:0] qdr_addr,
    output logic        qdr_r,
    output logic        qdr_w,
    output logic [71:0] qdr_d,
    output logic [3:0]  qdr_be,
    input  logic [71:0] qdr_q,
    output logic        sniffer_latch_out
);

    localparam int CNT_W = $clog2(QDR_LATENCY + 1);
    // Counter value in the last RWAIT cycle, when qdr_q is due
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QDR_LATENCY - 1);

    state_t            state;
    state_t            state_nxt;
    logic              rnw_q;
    logic              hi_sel;
    logic [CNT_W-1:0]  lat_cnt;
    logic              unused_addr_bits;

    // Sub-word byte offset has no meaning on a 32-bit host port
    assign unused_addr_bits = ^host_addr[1:0];

    // State register
    always_ff @(posedge qdr_clk) begin
        if (!qdr_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_nxt         = state;
        qdr_req           = 1'b0;
        qdr_r             = 1'b0;
        qdr_w             = 1'b0;
        host_ack          = 1'b0;
        sniffer_latch_out = 1'b0;
        case (state)
            ST_IDLE: begin
                if (host_en) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                qdr_req = 1'b1;
                qdr_r   = rnw_q;
                qdr_w   = !rnw_q;
                if (qdr_ack) begin
                    state_nxt = rnw_q ? ST_RWAIT : ST_ACK;
                end
            end
            ST_RWAIT: begin
                if (lat_cnt == CNT_LAST) begin
                    sniffer_latch_out = 1'b1;
                    state_nxt         = ST_ACK;
                end
            end
            ST_ACK: begin
                host_ack  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture: address, lane-packed data and enables stay frozen until the next access
    always_ff @(posedge qdr_clk) begin
        if (!qdr_rst_n) begin
            rnw_q    <= 1'b0;
            hi_sel   <= 1'b0;
            qdr_addr <= '0;
            qdr_d    <= '0;
            qdr_be   <= '0;
        end else if (state == ST_IDLE && host_en) begin
            rnw_q    <= host_rnw;
            hi_sel   <= host_addr[2];
            qdr_addr <= {3'b000, host_addr[31:3]};
            qdr_d    <= {lane_pack(host_datai), lane_pack(host_datai)};
            qdr_be   <= host_rnw ? 4'b0000 : lane_be(host_be, host_addr[2]);
        end
    end

    // Read latency counter: cleared on the read grant, advances while waiting
    always_ff @(posedge qdr_clk) begin
        if (!qdr_rst_n) begin
            lat_cnt <= '0;
        end else if (state == ST_REQ && qdr_ack) begin
            lat_cnt <= '0;
        end else if (state == ST_RWAIT) begin
            lat_cnt <= lat_cnt + CNT_W'(1);
        end
    end

    // Read data capture of the selected half; held until the next capture
    always_ff @(posedge qdr_clk) begin
        if (!qdr_rst_n) begin
            host_datao <= '0;
        end else if (sniffer_latch_out) begin
            host_datao <= lane_unpack(hi_sel ? qdr_q[WORD_W-1:HALF_W] : qdr_q[HALF_W-1:0]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qdr_backdoor_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_qdr_backdoor_bridge
// Description : Directed bench for qdr_backdoor_bridge; two instances with
//               QDR_LATENCY 10 and 1 share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qdr_backdoor_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_en;
    logic        host_rnw;
    logic [31:0] host_addr;
    logic [31:0] host_datai;
    logic [3:0]  host_be;
    logic        qdr_ack;
    logic [71:0] qdr_q;

    logic [31:0] datao_a, datao_b;
    logic        hack_a, hack_b;
    logic        req_a, req_b;
    logic [31:0] addr_a, addr_b;
    logic        r_a, r_b, w_a, w_b;
    logic [71:0] d_a, d_b;
    logic [3:0]  be_a, be_b;
    logic        snif_a, snif_b;

    int passed = 0;
    int total  = 0;

    logic [35:0] exp_half;

    always #5 clk = ~clk;

    qdr_backdoor_bridge #(.QDR_LATENCY(10)) dut (
        .qdr_clk(clk), .qdr_rst_n(rst_n),
        .host_en(host_en), .host_rnw(host_rnw), .host_addr(host_addr),
        .host_datai(host_datai), .host_be(host_be),
        .host_datao(datao_a), .host_ack(hack_a),
        .qdr_req(req_a), .qdr_ack(qdr_ack), .qdr_addr(addr_a),
        .qdr_r(r_a), .qdr_w(w_a), .qdr_d(d_a), .qdr_be(be_a),
        .qdr_q(qdr_q), .sniffer_latch_out(snif_a)
    );

    qdr_backdoor_bridge #(.QDR_LATENCY(1)) dut_l1 (
        .qdr_clk(clk), .qdr_rst_n(rst_n),
        .host_en(host_en), .host_rnw(host_rnw), .host_addr(host_addr),
        .host_datai(host_datai), .host_be(host_be),
        .host_datao(datao_b), .host_ack(hack_b),
        .qdr_req(req_b), .qdr_ack(qdr_ack), .qdr_addr(addr_b),
        .qdr_r(r_b), .qdr_w(w_b), .qdr_d(d_b), .qdr_be(be_b),
        .qdr_q(qdr_q), .sniffer_latch_out(snif_b)
    );

    // Advance to 1 time unit past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic start(input logic rnw, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        host_en    = 1'b1;
        host_rnw   = rnw;
        host_addr  = a;
        host_datai = d;
        host_be    = be;
    endtask

    initial begin
        rst_n = 1'b0; host_en = 1'b0; host_rnw = 1'b0; host_addr = '0;
        host_datai = '0; host_be = '0; qdr_ack = 1'b0; qdr_q = '0;

        // ---------------- reset state
        tick(); tick(); tick();
        chk("rst_req",   {71'd0, req_a},  72'd0);
        chk("rst_ack",   {71'd0, hack_a}, 72'd0);
        chk("rst_addr",  {40'd0, addr_a}, 72'd0);
        chk("rst_d",     d_a,             72'd0);
        chk("rst_datao", {40'd0, datao_a}, 72'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- write 0x10, full word, immediate grant
        qdr_ack = 1'b1;
        start(1'b0, 32'h10, 32'hA1B2C3D4, 4'hF);
        chk("w1_c0_ack", {71'd0, hack_a}, 72'd0);
        tick(); host_en = 1'b0;
        exp_half = {1'b0, 8'hA1, 1'b0, 8'hB2, 1'b0, 8'hC3, 1'b0, 8'hD4};
        chk("w1_req",  {71'd0, req_a},  72'd1);
        chk("w1_w",    {70'd0, w_a, r_a}, 72'd2);
        chk("w1_addr", {40'd0, addr_a}, 72'd2);
        chk("w1_be",   {68'd0, be_a},   72'h3);
        chk("w1_d",    d_a,             {exp_half, exp_half});
        chk("w1_c1_ack", {71'd0, hack_a}, 72'd0);
        tick();
        chk("w1_c2_ack", {71'd0, hack_a}, 72'd1);
        chk("w1_c2_req", {71'd0, req_a},  72'd0);
        tick();
        chk("w1_c3_ack", {71'd0, hack_a}, 72'd0);

        // ---------------- write 0x14, byte 2 only -> hi half lane 1
        start(1'b0, 32'h14, 32'h01020304, 4'b0100);
        tick(); host_en = 1'b0;
        chk("w2_be",   {68'd0, be_a},   72'h8);
        chk("w2_addr", {40'd0, addr_a}, 72'd2);
        tick();
        chk("w2_ack",  {71'd0, hack_a}, 72'd1);
        tick();

        // ---------------- read 0x1C, hi half with parity bits set
        qdr_q = {1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 8'h33, 1'b1, 8'h44, 36'hF_FFFF_FFFF};
        start(1'b1, 32'h1C, 32'h0, 4'h0);
        tick(); host_en = 1'b0;
        chk("r_r",    {70'd0, r_a, w_a}, 72'd2);
        chk("r_addr", {40'd0, addr_a},   72'd3);
        for (int c = 2; c <= 13; c++) begin
            tick();
            chk($sformatf("r_ack_c%0d", c),  {71'd0, hack_a}, {71'd0, (c == 12)});
            chk($sformatf("r_snif_c%0d", c), {71'd0, snif_a}, {71'd0, (c == 11)});
            chk($sformatf("r1_ack_c%0d", c), {71'd0, hack_b}, {71'd0, (c == 3)});
            if (c == 12) chk("r_datao", {40'd0, datao_a}, {40'd0, 32'h11223344});
        end
        chk("r_datao_held", {40'd0, datao_a}, {40'd0, 32'h11223344});
        chk("r1_datao",     {40'd0, datao_b}, {40'd0, 32'h11223344});

        // ---------------- write 0x20 with grant held off until cycle 5
        qdr_ack = 1'b0;
        start(1'b0, 32'h20, 32'h55667788, 4'b0011);
        exp_half = {1'b0, 8'h55, 1'b0, 8'h66, 1'b0, 8'h77, 1'b0, 8'h88};
        for (int c = 1; c <= 9; c++) begin
            tick();
            host_en = (c == 2);
            if (c == 2) begin
                host_addr = 32'h40; host_datai = 32'hDEADBEEF; host_be = 4'hF;
            end
            qdr_ack = (c == 5);
            if (c <= 5) begin
                chk($sformatf("g_req_c%0d", c),  {71'd0, req_a},  72'd1);
                chk($sformatf("g_addr_c%0d", c), {40'd0, addr_a}, 72'd4);
                chk($sformatf("g_be_c%0d", c),   {68'd0, be_a},   72'h1);
                chk($sformatf("g_d_c%0d", c),    d_a,             {exp_half, exp_half});
            end else begin
                chk($sformatf("g_req_c%0d", c),  {71'd0, req_a},  72'd0);
            end
            chk($sformatf("g_ack_c%0d", c), {71'd0, hack_a}, {71'd0, (c == 6)});
        end
        host_en = 1'b0; qdr_ack = 1'b1;

        // ---------------- read interrupted by reset during RWAIT
        start(1'b1, 32'h8, 32'h0, 4'h0);
        tick(); host_en = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("rr_req",   {71'd0, req_a},   72'd0);
        chk("rr_ack",   {71'd0, hack_a},  72'd0);
        chk("rr_snif",  {71'd0, snif_a},  72'd0);
        chk("rr_addr",  {40'd0, addr_a},  72'd0);
        chk("rr_datao", {40'd0, datao_a}, 72'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            tick();
            chk($sformatf("rr_noack_%0d", c), {71'd0, hack_a}, 72'd0);
        end

        // ---------------- normal write after reset
        start(1'b0, 32'h14, 32'hCAFEF00D, 4'b1000);
        tick(); host_en = 1'b0;
        chk("pw_be",  {68'd0, be_a},   72'h8);
        chk("pw_req", {71'd0, req_a},  72'd1);
        tick();
        chk("pw_ack", {71'd0, hack_a}, 72'd1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
